// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per cycle.
module seq_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [DATA_W-1:0] Dividend_in,
    input  logic [DATA_W-1:0] Divisor_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Quotient,
    output logic [DATA_W-1:0] Remainder,
    output logic              div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t              state;
    logic [2*DATA_W-1:0] rem;
    logic [DATA_W-1:0]   div;
    logic [5:0]          count;
    logic [DATA_W:0]     t;
    logic [DATA_W:0]     d;
    // t keeps the bit shifted out of the upper half; the partial remainder can reach 2*div-1
    assign t         = rem[2*DATA_W-1:DATA_W-1];
    assign d         = t - {1'b0, div};
    assign Quotient  = rem[DATA_W-1:0];
    assign Remainder = rem[2*DATA_W-1:DATA_W];
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            rem         <= '0;
            div         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    rem   <= d[DATA_W] ? {rem[2*DATA_W-2:0], 1'b0}
                                       : {d[DATA_W-1:0], rem[DATA_W-2:0], 1'b1};
                    count <= count + 6'd1;
                    if (count == 6'(DATA_W - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (!start) begin
                        state <= IDLE;
                    end else if (Divisor_in != '0) begin
                        rem         <= {{DATA_W{1'b0}}, Dividend_in};
                        div         <= Divisor_in;
                        count       <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end else begin
                        rem         <= {Dividend_in, {DATA_W{1'b1}}};
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table plus handshake corner cases and random operands.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        Reset, start, busy, done, div_by_zero;
    logic [31:0] Dividend_in, Divisor_in, Quotient, Remainder;
    int          n_chk = 0;
    int          n_fail = 0;
    int          overlap = 0;

    seq_divider dut (
        .clk(clk), .Reset(Reset), .start(start),
        .Dividend_in(Dividend_in), .Divisor_in(Divisor_in),
        .busy(busy), .done(done), .Quotient(Quotient),
        .Remainder(Remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap++;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // called at a negedge; returns at the negedge of the first cycle after acceptance
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        Dividend_in = a;
        Divisor_in  = b;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts cycles after the accepting edge; stops at the done cycle or the bound
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[6];
        int          lat, nbusy, pulses;
        logic [31:0] a, b;
        vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
        vecs[3] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000001, 32'd0, 32'h80000000, 1'b0};
        vecs[5] = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1};

        Reset = 1'b1; start = 1'b0; Dividend_in = '0; Divisor_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_q", Quotient, 0);
        chk("reset_r", Remainder, 0);
        chk("reset_dbz", div_by_zero, 0);
        Reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_done(lat, nbusy);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].z ? 1 : 33);
            chk($sformatf("v%0d_busy_cycles", i), nbusy, vecs[i].z ? 0 : 32);
            chk($sformatf("v%0d_q", i), Quotient, vecs[i].q);
            chk($sformatf("v%0d_r", i), Remainder, vecs[i].r);
            chk($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].z);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_idle_hold", i), {Remainder, Quotient}, {vecs[i].r, vecs[i].q});
        end

        // mid-run start must be ignored; start held in DONE chains with no bubble
        issue(32'd200, 32'd9);
        repeat (9) @(negedge clk);
        issue(32'd50, 32'd5);
        wait_done(lat, nbusy);
        chk("midrun_latency", lat + 10, 33);
        chk("midrun_q", Quotient, 22);
        chk("midrun_r", Remainder, 2);
        issue(32'd50, 32'd5);
        chk("b2b_busy", busy, 1);
        chk("b2b_done", done, 0);
        wait_done(lat, nbusy);
        chk("b2b_latency", lat, 33);
        chk("b2b_q", Quotient, 10);
        chk("b2b_r", Remainder, 0);
        @(negedge clk);

        // reset during RUN, with a simultaneous start that must be ignored
        issue(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        Reset = 1'b1; start = 1'b1; Dividend_in = 32'd9; Divisor_in = 32'd2;
        @(negedge clk);
        Reset = 1'b0; start = 1'b0;
        chk("rst_run_busy", busy, 0);
        chk("rst_run_done", done, 0);
        chk("rst_run_q", Quotient, 0);
        chk("rst_run_r", Remainder, 0);
        chk("rst_run_dbz", div_by_zero, 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("rst_run_quiet", pulses, 0);

        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (b == 0) b = 32'd1;
            issue(a, b);
            wait_done(lat, nbusy);
            chk($sformatf("rnd%0d_latency", i), lat, 33);
            chk($sformatf("rnd%0d_q %0h/%0h", i, a, b), Quotient, a / b);
            chk($sformatf("rnd%0d_r %0h/%0h", i, a, b), Remainder, a % b);
            chk($sformatf("rnd%0d_identity", i),
                64'(Quotient) * 64'(b) + 64'(Remainder), 64'(a));
            @(negedge clk);
        end

        chk("busy_done_overlap", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
